interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// Four-source interrupt controller: INT0 non-maskable, INT3..1 maskable, fixed priority, vectored.
// Optional macro INTC_NMI_PREEMPT_EN lets a pending INT0 preempt a maskable handler (nesting depth 2).
module interrupt_controller #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic [15:0] VECTOR_BASE   = 16'h0004,
    parameter logic [15:0] VECTOR_STRIDE = 16'h0004
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [3:0]  INT,
    input  logic        IACK,
    input  logic        EI,
    input  logic        DI,
    input  logic        RETI,
    output logic        IRQ,
    output logic [15:0] VECTOR,
    output logic        IE,
    output logic [3:0]  IN_SERVICE
);

    localparam int unsigned NSRC = 4;
    localparam int unsigned IDW  = 2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q, sync_d;
    logic [NSRC-1:0]  prev_q, prev_d;
    logic [NSRC-1:0]  pend_q, pend_d, pend_clr;
    logic [NSRC-1:0]  insvc_q, insvc_d;
    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             irq_q, irq_d;
    logic             ie_q, ie_d;
    logic [15:0]      vector_q, vector_d;

    logic [NSRC-1:0]  rise;
    logic [NSRC-1:0]  eligible;
    logic [IDW-1:0]   pick_id;
    logic [IDW-1:0]   svc_top;

    function automatic logic [15:0] vec_of(input logic [IDW-1:0] id);
        return VECTOR_BASE + VECTOR_STRIDE * 16'(id);
    endfunction

    // Synchronizer chain and rising-edge detect on the last stage
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], INT};
        prev_d = sync_q[SYNC_STAGES-1];
        rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // Maskable sources only when enabled and nothing is in service
    always_comb begin
        eligible = pend_q & {{(NSRC-1){ie_q & ~(|insvc_q)}}, 1'b1};
        pick_id  = '0;
        svc_top  = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) pick_id = IDW'(i);
            if (insvc_q[i])  svc_top = IDW'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        irq_d    = irq_q;
        vector_d = vector_q;
        insvc_d  = insvc_q;
        pend_clr = '0;
        ie_d     = ie_q;
        if (EI) ie_d = 1'b1;
        if (DI) ie_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d  = ST_REQ;
                    id_d     = pick_id;
                    vector_d = vec_of(pick_id);
                    irq_d    = 1'b1;
                end
            end
            ST_REQ: begin
                if (IACK) begin
                    irq_d    = 1'b0;
                    insvc_d  = insvc_q | (4'b0001 << id_q);
                    pend_clr = 4'b0001 << id_q;
                    state_d  = ST_SERVICE;
                    if (id_q != '0) ie_d = 1'b0;
                end else if (id_q != '0 && pend_q[0]) begin
                    id_d     = '0;
                    vector_d = vec_of('0);
                end else if (DI && id_q != '0) begin
                    irq_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (RETI) begin
                    insvc_d = insvc_q & ~(4'b0001 << svc_top);
                    if (svc_top != '0) ie_d = 1'b1;
                    if ((insvc_q & ~(4'b0001 << svc_top)) == '0) state_d = ST_IDLE;
                end
`ifdef INTC_NMI_PREEMPT_EN
                else if (!insvc_q[0] && pend_q[0]) begin
                    state_d  = ST_REQ;
                    id_d     = '0;
                    vector_d = vec_of('0);
                    irq_d    = 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh edge in the acknowledge cycle keeps the source pending
        pend_d = (pend_q & ~pend_clr) | rise;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync_q   <= '0;
            prev_q   <= '0;
            pend_q   <= '0;
            insvc_q  <= '0;
            state_q  <= ST_IDLE;
            id_q     <= '0;
            irq_q    <= 1'b0;
            ie_q     <= 1'b0;
            vector_q <= '0;
        end else begin
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            pend_q   <= pend_d;
            insvc_q  <= insvc_d;
            state_q  <= state_d;
            id_q     <= id_d;
            irq_q    <= irq_d;
            ie_q     <= ie_d;
            vector_q <= vector_d;
        end
    end

    assign IRQ        = irq_q;
    assign VECTOR     = vector_q;
    assign IE         = ie_q;
    assign IN_SERVICE = insvc_q;

endmodule
